// File: rtl/ps2_key_decoder.sv
// PS/2 device-to-host receiver with make/break key tracking.
// Outputs the held key's scan code, a held level, an extended flag and a press counter.
module ps2_key_decoder #(
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] scan_code,
   output logic       key_valid,
   output logic [7:0] key_count,
   output logic       ext_key,
   output logic       rx_ready,
   output logic       frame_err
);

   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES);
   localparam logic [7:0] CodeExt = 8'hE0;
   localparam logic [7:0] CodeBrk = 8'hF0;

   typedef enum logic [1:0] {StIdle, StPressed, StBreak} state_e;

   logic [2:0]      clk_sync_q;
   logic [1:0]      data_sync_q;
   logic [3:0]      bit_cnt_q;
   logic [9:0]      shift_q;
   logic [TmoW-1:0] tmo_q;

   logic        fall;
   logic        bit_in;
   logic        frame_end;
   logic [10:0] frame;
   logic        frame_ok;
   logic        byte_valid;
   logic [7:0]  rx_byte;

   assign fall       = clk_sync_q[2] & ~clk_sync_q[1];
   assign bit_in     = data_sync_q[1];
   assign frame_end  = fall && (bit_cnt_q == 4'd10);
   // Bit 10 (stop) arrives live in the edge cycle; bits 0..9 are already shifted in.
   assign frame      = {bit_in, shift_q};
   assign frame_ok   = ~frame[0] & frame[10] & (^frame[9:1]);
   assign byte_valid = frame_end & frame_ok;
   assign rx_byte    = frame[8:1];

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         clk_sync_q  <= 3'b111;
         data_sync_q <= 2'b11;
         bit_cnt_q   <= 4'd0;
         shift_q     <= 10'd0;
         tmo_q       <= '0;
      end else begin
         clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
         data_sync_q <= {data_sync_q[0], ps2_data};
         if (fall) begin
            shift_q   <= {bit_in, shift_q[9:1]};
            tmo_q     <= '0;
            bit_cnt_q <= (bit_cnt_q == 4'd10) ? 4'd0 : bit_cnt_q + 4'd1;
         end else if (bit_cnt_q != 4'd0) begin
            // A stalled partial frame is dropped without raising frame_err.
            if (tmo_q == TmoMax) begin
               bit_cnt_q <= 4'd0;
               tmo_q     <= '0;
            end else begin
               tmo_q <= tmo_q + 1'b1;
            end
         end
      end
   end

   state_e     state_q, state_d;
   logic [7:0] scan_q, scan_d;
   logic [7:0] count_q, count_d;
   logic       valid_q, valid_d;
   logic       ext_q, ext_d;
   logic       pend_q, pend_d;
   logic       rx_ready_q, rx_ready_d;
   logic       frame_err_q, frame_err_d;

   always_comb begin
      state_d     = state_q;
      scan_d      = scan_q;
      count_d     = count_q;
      valid_d     = valid_q;
      ext_d       = ext_q;
      pend_d      = pend_q;
      rx_ready_d  = byte_valid;
      frame_err_d = frame_end & ~frame_ok;
      if (byte_valid) begin
         pend_d = (rx_byte == CodeExt) && (state_q != StBreak);
         unique case (state_q)
            StIdle, StPressed: begin
               if (rx_byte == CodeExt) begin
                  pend_d = 1'b1;
               end else if (rx_byte == CodeBrk) begin
                  state_d = StBreak;
               end else if (!(state_q == StPressed && rx_byte == scan_q)) begin
                  scan_d  = rx_byte;
                  ext_d   = pend_q;
                  valid_d = 1'b1;
                  count_d = count_q + 8'd1;
                  state_d = StPressed;
               end
            end
            StBreak: begin
               valid_d = 1'b0;
               state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q     <= StIdle;
         scan_q      <= 8'd0;
         count_q     <= 8'd0;
         valid_q     <= 1'b0;
         ext_q       <= 1'b0;
         pend_q      <= 1'b0;
         rx_ready_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         scan_q      <= scan_d;
         count_q     <= count_d;
         valid_q     <= valid_d;
         ext_q       <= ext_d;
         pend_q      <= pend_d;
         rx_ready_q  <= rx_ready_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign scan_code = scan_q;
   assign key_valid = valid_q;
   assign key_count = count_q;
   assign ext_key   = ext_q;
   assign rx_ready  = rx_ready_q;
   assign frame_err = frame_err_q;

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Upstream of the two-digit hex 7-segment driver in the PS/2 keyboard lab.
- Deserialises PS/2 device-to-host frames and validates start, parity and stop bits.
- Tracks the make/break protocol and presents the held key's scan code plus a display-enable level.
- Maintains an 8-bit press counter that a second hex display pair can show.

Parameters:
TIMEOUT_CYCLES, 50000, clk cycles without a PS/2 falling edge before a partial frame is discarded (1 ms at 50 MHz)

Ports:
clk  input  1  system clock; all state on rising edge
clrn  input  1  asynchronous active-low reset
ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous
ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous
scan_code  output  8  make code of the most recently pressed key
key_valid  output  1  high while a key is held; drives the display enable
key_count  output  8  count of distinct key presses, binary, wraps
ext_key  output  1  latched high when the current make code was prefixed by 0xE0
rx_ready  output  1  one-cycle pulse per accepted frame
frame_err  output  1  one-cycle pulse per rejected frame

Behaviour:
- Reset (clrn=0, asynchronous):
  - All outputs 0: scan_code=0x00, key_valid=0, key_count=0, ext_key=0, rx_ready=0, frame_err=0.
  - Synchronisers preset to 1; bit counter, timeout counter and FSM cleared to IDLE.
- Reset mid-frame abandons the frame. Reception restarts at the next start bit.
- Synchronisation:
  - ps2_clk passes through a 3-flop chain s[0..2].
  - Falling edge = s[2]==1 && s[1]==0.
  - ps2_data passes through a 2-flop chain and is sampled in the edge cycle.
- Frame: 11 bits, LSB-first. Bit 0 start (0), bits 1-8 data, bit 9 odd parity, bit 10 stop (1).
  - Bit counter runs 0..10 and advances on each falling edge.
  - On the 11th edge the counter returns to 0 and the frame is checked.
- Frame check:
  - Valid = start==0, stop==1, and XOR(data, parity)==1.
  - Valid frame: rx_ready=1 in the cycle after the 11th edge; the byte goes to the key FSM in that same cycle.
  - Invalid frame: frame_err=1 in the cycle after the 11th edge. Byte discarded; no FSM, count or output change.
- Timeout:
  - Counter clears on each falling edge; counts only while the bit counter is nonzero.
  - On reaching TIMEOUT_CYCLES the bit counter clears silently (no frame_err).
- Key FSM states: IDLE, PRESSED, BREAK. A pending-extend flag is set by byte 0xE0 and cleared by any other byte.
  - IDLE + 0xE0: set pending-extend; stay in IDLE.
  - IDLE + 0xF0: go to BREAK (stray release).
  - IDLE + any other byte: scan_code=byte; ext_key=pending-extend; key_valid=1; key_count+1; go to PRESSED.
  - PRESSED + byte == scan_code (typematic repeat): no change, no count.
  - PRESSED + 0xE0: set pending-extend.
  - PRESSED + 0xF0: go to BREAK.
  - PRESSED + other byte (new key while held): scan_code=byte; ext_key=pending-extend; key_count+1; stay in PRESSED.
  - BREAK + any byte: key_valid=0; go to IDLE. scan_code and ext_key hold their last value.
  - 0xE0 received in BREAK is consumed as the released code.
- All output updates from a byte land in the same cycle rx_ready pulses.
- key_count wraps 0xFF -> 0x00.
- Bytes 0xAA (self-test) and 0xFA (ack) are treated as ordinary codes; no special handling.
- Outputs are registered; no combinational path from ps2_* to outputs.

Test Plan:
1. Reset, then frame 0x1C with parity 0 -> rx_ready pulse; scan_code=0x1C, key_valid=1, key_count=1, ext_key=0.
2. 0x1C, 0x1C, 0x1C, then 0xF0, 0x1C -> key_count stays 1 through the repeats; key_valid=0 after the second release byte; scan_code remains 0x1C.
3. 0xE0, 0x75 (ext up-arrow), then 0xE0, 0xF0, 0x75 -> scan_code=0x75, ext_key=1, key_count+1; key_valid=0 after the final byte.
4. Frame 0x1C with parity 1 (wrong) -> frame_err pulse one cycle after the 11th edge; no rx_ready, all outputs unchanged.
5. Five bits of a frame, then idle for TIMEOUT_CYCLES+10, then a full 0x32 frame -> no frame_err; scan_code=0x32.
6. 256 press/release pairs -> key_count returns to 0x00. Separately, clrn pulsed low at bit 6 of a frame -> all outputs 0; the next full frame decodes correctly.
